rwg_multi: RTL

// - Parametrised multi-seed random weight generator for the ELM hidden layer.
// - Generates pseudo-random input weights from a Fibonacci LFSR (right shift, XOR feedback into MSB).
// - Seeds come from a programmable seed table, and one start can chain several seed blocks.
// - Weights stream to the hidden-neuron MAC array over a valid/ready handshake, each with a global weight index.

---
 rtl/rwg_pkg.sv | 24 ++
 rtl/rwg_seed_ram.sv | 33 +++
 rtl/rwg_multi.sv | 117 +++++++++++
 3 files changed

// File: rtl/rwg_pkg.sv
// rtl/rwg_pkg.sv - shared types and helpers for the random weight generator
package rwg_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} rwg_state_e;

  // Fibonacci step: shift right, parity of tapped bits enters at the MSB.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s, input logic [31:0] mask,
                                            input int unsigned w);
    logic fb;
    fb = ^(s & mask);
    return (s >> 1) | ({31'd0, fb} << (w - 1));
  endfunction

  // A zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] default_seed(input int unsigned i, input logic [31:0] seed0,
                                               input logic [31:0] step, input int unsigned w);
    logic [31:0] m;
    logic [31:0] v;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    v = (seed0 + i * step) & m;
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/rwg_seed_ram.sv
// rtl/rwg_seed_ram.sv - seed table, one write port, one async read port, resets to defaults
module rwg_seed_ram
  import rwg_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NUM_SEEDS = 12,
  parameter logic [WIDTH-1:0] SEED0 = 11'b010_1101_0110,
  parameter logic [WIDTH-1:0] SEED_STEP = 11'h2D3,
  localparam int AW = $clog2(NUM_SEEDS)
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [NUM_SEEDS];

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SEEDS; i++)
        mem[i] <= WIDTH'(default_seed(i, 32'(SEED0), 32'(SEED_STEP), WIDTH));
    end else if (we && int'(waddr) < NUM_SEEDS) begin
      mem[waddr] <= (wdata == '0) ? WIDTH'(1) : wdata;
    end
  end

  assign rdata = (int'(raddr) < NUM_SEEDS) ? mem[raddr] : mem[0];

endmodule

// File: rtl/rwg_multi.sv
// rtl/rwg_multi.sv - multi-seed LFSR weight generator streaming indexed weights to the MAC array
module rwg_multi
  import rwg_pkg::*;
#(
  parameter int WIDTH = 11,
  parameter int NUM_SEEDS = 12,
  parameter int WPS = 11,
  parameter logic [WIDTH-1:0] TAP_MASK = 11'b101_0000_0000,
  parameter logic [WIDTH-1:0] SEED0 = 11'b010_1101_0110,
  parameter logic [WIDTH-1:0] SEED_STEP = 11'h2D3,
  localparam int AW = $clog2(NUM_SEEDS),
  localparam int IW = $clog2(NUM_SEEDS * WPS)
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             seed_we,
  input  logic [AW-1:0]    seed_waddr,
  input  logic [WIDTH-1:0] seed_wdata,
  input  logic             start,
  input  logic [AW-1:0]    seed_sel,
  input  logic [AW:0]      num_blk,
  input  logic             abort,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [WIDTH-1:0] w_data,
  output logic [IW-1:0]    w_idx,
  output logic             busy,
  output logic             done
);

  localparam int KW = (WPS > 1) ? $clog2(WPS) : 1;

  rwg_state_e       state;
  logic [WIDTH-1:0] lfsr;
  logic [KW-1:0]    k;
  logic [AW-1:0]    blk;
  logic [AW:0]      blocks_left;
  logic [AW-1:0]    nxt_blk;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    sel_c;
  logic [WIDTH-1:0] seed_rd;
  logic [WIDTH-1:0] lfsr_adv;

  assign nxt_blk  = (int'(blk) == NUM_SEEDS - 1) ? '0 : blk + 1'b1;
  assign sel_c    = (int'(seed_sel) < NUM_SEEDS) ? seed_sel : '0;
  // The single read port serves the start seed in IDLE and the next block seed in RUN.
  assign rd_addr  = (state == IDLE) ? sel_c : nxt_blk;
  assign lfsr_adv = WIDTH'(lfsr_next(32'(lfsr), 32'(TAP_MASK), WIDTH));

  rwg_seed_ram #(
    .WIDTH(WIDTH), .NUM_SEEDS(NUM_SEEDS), .SEED0(SEED0), .SEED_STEP(SEED_STEP)
  ) u_seed_ram (
    .clk2  (clk2),
    .rst_n (rst_n),
    .we    (seed_we && state == IDLE),
    .waddr (seed_waddr),
    .wdata (seed_wdata),
    .raddr (rd_addr),
    .rdata (seed_rd)
  );

  always_ff @(posedge clk2 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      lfsr        <= '0;
      k           <= '0;
      blk         <= '0;
      blocks_left <= '0;
      w_valid     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        w_valid <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start) begin
            lfsr        <= seed_rd;
            k           <= '0;
            blk         <= sel_c;
            blocks_left <= (num_blk == '0) ? (AW+1)'(1) : num_blk;
            w_valid     <= 1'b1;
            busy        <= 1'b1;
            state       <= RUN;
          end
          RUN: if (w_valid && w_ready) begin
            if (int'(k) == WPS - 1) begin
              if (blocks_left > (AW+1)'(1)) begin
                blk         <= nxt_blk;
                lfsr        <= seed_rd;
                k           <= '0;
                blocks_left <= blocks_left - 1'b1;
              end else begin
                w_valid <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= DONE;
              end
            end else begin
              lfsr <= lfsr_adv;
              k    <= k + 1'b1;
            end
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign w_data = lfsr;
  assign w_idx  = IW'(32'(blk) * WPS + 32'(k));

endmodule
